// File: rtl/a4_pair_fifo.sv
// Pairs the scalar level-4 approximation stream into even/odd beats and buffers them
// in a first-word-fall-through FIFO with a ready/valid output and sticky overflow flag.
module a4_pair_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_312_5,
    input  logic              rst,
    input  logic              flush,
    input  logic              din_valid,
    input  logic [31:0]       a4_0,
    input  logic              dout_ready,
    output logic              dout_valid,
    output logic [31:0]       a4_pair_0,
    output logic [31:0]       a4_pair_1,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic              phase_q, phase_d;
    logic [31:0]       holdData_q, holdData_d;
    logic              pendValid_q, pendValid_d;
    logic [63:0]       pendPair_q, pendPair_d;
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [63:0]       outPair_q, outPair_d;
    logic              overflow_q, overflow_d;
    logic [63:0]       mem_q [DEPTH];

    logic pop;
    logic push;
    logic drop;

    // A completed pair sits in the pending register for one cycle before entering the
    // FIFO, which gives the one-cycle gap between the odd sample and dout_valid.
    always_comb begin
        pop        = (count_q != '0) && dout_ready;
        push       = pendValid_q && ((count_q < FULL_COUNT) || pop);
        drop       = pendValid_q && !push;

        wrPtr_d    = wrPtr_q + ADDR_W'(push);
        rdPtr_d    = rdPtr_q + ADDR_W'(pop);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        outPair_d  = outPair_q;
        if (count_d != '0) begin
            if (push && (rdPtr_d == wrPtr_q)) begin
                outPair_d = pendPair_q;
            end else begin
                outPair_d = mem_q[rdPtr_d];
            end
        end

        overflow_d = overflow_q | drop;

        phase_d     = phase_q;
        holdData_d  = holdData_q;
        pendValid_d = 1'b0;
        pendPair_d  = pendPair_q;
        if (din_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                holdData_d = a4_0;
            end else begin
                pendValid_d = 1'b1;
                pendPair_d  = {holdData_q, a4_0};
            end
        end
    end

    always_ff @(posedge clk_312_5) begin
        if (rst) begin
            phase_q     <= 1'b0;
            holdData_q  <= '0;
            pendValid_q <= 1'b0;
            pendPair_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            outPair_q   <= '0;
            overflow_q  <= 1'b0;
        end else if (flush) begin
            phase_q     <= 1'b0;
            pendValid_q <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            holdData_q  <= holdData_d;
            pendValid_q <= pendValid_d;
            pendPair_q  <= pendPair_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            outPair_q   <= outPair_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_312_5) begin
        if (!rst && !flush && push) begin
            mem_q[wrPtr_q] <= pendPair_q;
        end
    end

    assign dout_valid = (count_q != '0);
    assign a4_pair_0  = outPair_q[63:32];
    assign a4_pair_1  = outPair_q[31:0];
    assign fill_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_a4_pair_fifo.sv
// Self-checking bench for a4_pair_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_a4_pair_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clock;
    logic              rst;
    logic              flush;
    logic              dinValid;
    logic [31:0]       a4In;
    logic              doutReady;
    logic              doutValid;
    logic [31:0]       pair0;
    logic [31:0]       pair1;
    logic [ADDR_W:0]   fillLevel;
    logic              overflowFlag;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    // Reference model state: a plain queue of pairs plus the pairing and in-flight pair.
    logic [63:0] modelQ[$];
    bit          mPhase;
    logic [31:0] mHold;
    bit          mPendValid;
    logic [63:0] mPend;
    bit          mOvf;
    logic [31:0] mLast0;
    logic [31:0] mLast1;

    a4_pair_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_312_5 (clock),
        .rst       (rst),
        .flush     (flush),
        .din_valid (dinValid),
        .a4_0      (a4In),
        .dout_ready(doutReady),
        .dout_valid(doutValid),
        .a4_pair_0 (pair0),
        .a4_pair_1 (pair1),
        .fill_level(fillLevel),
        .overflow  (overflowFlag)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 2 time units after the edge that sampled them.
    task automatic applyStimulus(input bit dv, input logic [31:0] d, input bit rdy, input bit fl, input bit rs);
        dinValid  = dv;
        a4In      = d;
        doutReady = rdy;
        flush     = fl;
        rst       = rs;
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin
        if (rst) begin
            modelQ.delete();
            mPhase     = 0;
            mPendValid = 0;
            mOvf       = 0;
            mLast0     = '0;
            mLast1     = '0;
        end else if (flush) begin
            modelQ.delete();
            mPhase     = 0;
            mPendValid = 0;
            mOvf       = 0;
        end else begin
            if (modelQ.size() != 0 && doutReady) void'(modelQ.pop_front());
            if (mPendValid) begin
                if (modelQ.size() < DEPTH) modelQ.push_back(mPend);
                else mOvf = 1;
            end
            mPendValid = 0;
            if (dinValid) begin
                if (!mPhase) mHold = a4In;
                else begin
                    mPend      = {mHold, a4In};
                    mPendValid = 1;
                end
                mPhase = !mPhase;
            end
            if (modelQ.size() != 0) begin
                mLast0 = modelQ[0][63:32];
                mLast1 = modelQ[0][31:0];
            end
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("dout_valid", 64'(doutValid), 64'(modelQ.size() != 0));
            checkOutput("fill_level", 64'(fillLevel), 64'(modelQ.size()));
            checkOutput("overflow", 64'(overflowFlag), 64'(mOvf));
            checkOutput("a4_pair_0", 64'(pair0), 64'(mLast0));
            checkOutput("a4_pair_1", 64'(pair1), 64'(mLast1));
        end
    end

    task automatic doReset();
        applyStimulus(0, '0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] base;
        dinValid = 0; a4In = '0; doutReady = 0; flush = 0; rst = 1;
        doReset();
        doReset();
        checkEn = 1;

        // Reset state and first pair latency
        checkOutput("reset_valid", 64'(doutValid), 64'd0);
        checkOutput("reset_fill", 64'(fillLevel), 64'd0);
        checkOutput("reset_pair0", 64'(pair0), 64'd0);
        applyStimulus(1, 32'h3f800000, 0, 0, 0);
        applyStimulus(1, 32'h40000000, 0, 0, 0);
        checkOutput("lat_not_yet", 64'(doutValid), 64'd0);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("t1_valid", 64'(doutValid), 64'd1);
        checkOutput("t1_pair0", 64'(pair0), 64'h3f800000);
        checkOutput("t1_pair1", 64'(pair1), 64'h40000000);
        checkOutput("t1_fill", 64'(fillLevel), 64'd1);

        // Nine pairs into an eight-deep FIFO, then drain
        doReset();
        base = 32'h10000000;
        for (int i = 0; i < 18; i++) applyStimulus(1, base + 32'(i), 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("t2_fill", 64'(fillLevel), 64'd8);
        checkOutput("t2_ovf", 64'(overflowFlag), 64'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_drain0", 64'(pair0), 64'(base + 32'(2 * i)));
            checkOutput("t2_drain1", 64'(pair1), 64'(base + 32'(2 * i + 1)));
            applyStimulus(0, '0, 1, 0, 0);
        end
        checkOutput("t2_empty", 64'(doutValid), 64'd0);
        checkOutput("t2_hold1", 64'(pair1), 64'(base + 32'd15));

        // Full FIFO accepts a pair when a pop happens alongside
        doReset();
        base = 32'h20000000;
        for (int i = 0; i < 16; i++) applyStimulus(1, base + 32'(i), 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        applyStimulus(1, 32'h2000aaaa, 0, 0, 0);
        applyStimulus(1, 32'h2000bbbb, 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("t3_fill", 64'(fillLevel), 64'd8);
        checkOutput("t3_ovf", 64'(overflowFlag), 64'd0);
        checkOutput("t3_front", 64'(pair0), 64'(base + 32'd2));

        // Flush discards a half pair
        doReset();
        applyStimulus(1, 32'h3f800000, 0, 0, 0);
        applyStimulus(0, '0, 0, 1, 0);
        applyStimulus(1, 32'h40400000, 0, 0, 0);
        applyStimulus(1, 32'h40800000, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("t4_fill", 64'(fillLevel), 64'd1);
        checkOutput("t4_pair0", 64'(pair0), 64'h40400000);
        checkOutput("t4_pair1", 64'(pair1), 64'h40800000);

        // Gap between the halves of a pair
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(1, 32'h41000000, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 0, 0);
        applyStimulus(1, 32'h41100000, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("t5_fill", 64'(fillLevel), 64'd1);
        checkOutput("t5_pair0", 64'(pair0), 64'h41000000);
        checkOutput("t5_pair1", 64'(pair1), 64'h41100000);

        // Reset with three pairs stored and the consumer active
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h50000000 + 32'(i), 0, 0, 0);
        applyStimulus(1, 32'h50000010, 1, 0, 0);
        applyStimulus(1, 32'h50000011, 0, 0, 1);
        checkOutput("t6_valid", 64'(doutValid), 64'd0);
        checkOutput("t6_fill", 64'(fillLevel), 64'd0);
        checkOutput("t6_pair0", 64'(pair0), 64'd0);
        applyStimulus(1, 32'h60000000, 0, 0, 0);
        applyStimulus(1, 32'h60000001, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("t6_pair0", 64'(pair0), 64'h60000000);
        checkOutput("t6_pair1", 64'(pair1), 64'h60000001);

        // Randomized traffic with slow and fast consumer phases
        for (int blk = 0; blk < 12; blk++) begin
            int readyPct = (blk % 2 == 0) ? 20 : 80;
            for (int c = 0; c < 200; c++) begin
                applyStimulus(($urandom_range(0, 3) != 0),
                              $urandom,
                              ($urandom_range(0, 99) < readyPct),
                              ($urandom_range(0, 99) == 0),
                              ($urandom_range(0, 299) == 0));
            end
        end

        applyStimulus(0, '0, 0, 0, 0);
        checkEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
